// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification sequencer: pulses pll_rst, waits for a stable lock, then releases core reset.
// Optional feature: define PLL_RELOCK_COUNT_EN to build the saturating relock_count (tied to 0 otherwise).
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 100000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       core_rst_n,
    output logic       lock_ok,
    output logic [7:0] relock_count
);

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic               locked_s;
    logic               pll_rst_q;
    logic               core_rst_n_q;
    logic               lock_ok_q;

    assign locked_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s)                   state_d = ST_STABLE;
                else if (cnt_q == TIMEOUT_LAST) state_d = ST_PLL_RST;
            end
            ST_STABLE: begin
                // Loss of lock is tested first so it beats the terminal count.
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) state_d = ST_PLL_RST;
            end
            default: state_d = ST_PLL_RST;
        endcase
        if (soft_rst) state_d = ST_PLL_RST;

        // RUN has no timed exit, so its counter is parked at zero rather than free-running.
        if (soft_rst || (state_d != state_q) || (state_q == ST_RUN)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
            lock_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_q    <= (state_d == ST_PLL_RST);
            core_rst_n_q <= (state_d == ST_RUN);
            lock_ok_q    <= (state_d == ST_RUN);
        end
    end

    assign pll_rst    = pll_rst_q;
    assign core_rst_n = core_rst_n_q;
    assign lock_ok    = lock_ok_q;

`ifdef PLL_RELOCK_COUNT_EN
    logic       relock_inc;
    logic [7:0] relock_q;

    // Entering PLL_RST without soft_rst from WAIT_LOCK or RUN is exactly a timeout or a lock loss.
    assign relock_inc = !soft_rst && (state_d == ST_PLL_RST) &&
                        ((state_q == ST_WAIT_LOCK) || (state_q == ST_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= '0;
        end else if (relock_inc && (relock_q != '1)) begin
            relock_q <= relock_q + 8'd1;
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: cycle model compared every cycle plus directed literal checks.
module tb_pll_reset_sequencer;

    localparam int RST_C  = 4;
    localparam int TMO_C  = 50;
    localparam int STB_C  = 8;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       soft_rst;
    logic       pll_rst;
    logic       core_rst_n;
    logic       lock_ok;
    logic [7:0] relock_count;

    int n_checks = 0;
    int n_pass   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(RST_C),
        .LOCK_TIMEOUT  (TMO_C),
        .LOCK_STABLE   (STB_C),
        .CNT_W         (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .soft_rst     (soft_rst),
        .pll_rst      (pll_rst),
        .core_rst_n   (core_rst_n),
        .lock_ok      (lock_ok),
        .relock_count (relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic int exp_rc(input int v);
`ifdef PLL_RELOCK_COUNT_EN
        return (v > 255) ? 255 : v;
`else
        v = 0;
        return v;
`endif
    endfunction

    // Reference model: phase plus the edge number at which the phase was entered.
    int   m_ph     = P_RST;
    int   m_cyc    = 0;
    int   m_entry  = 0;
    int   m_relock = 0;
    logic m_h1     = 1'b0;
    logic m_h2     = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = P_RST; m_entry = m_cyc; m_relock = 0; m_h1 = 1'b0; m_h2 = 1'b0;
            end else begin
                int held;
                int nxt;
                m_cyc++;
                held = m_cyc - m_entry;
                nxt  = m_ph;
                if (soft_rst) nxt = P_RST;
                else if (m_ph == P_RST) begin
                    if (held >= RST_C) nxt = P_WAIT;
                end else if (m_ph == P_WAIT) begin
                    if (m_h2) nxt = P_STAB;
                    else if (held >= TMO_C) begin nxt = P_RST; m_relock++; end
                end else if (m_ph == P_STAB) begin
                    if (!m_h2) nxt = P_WAIT;
                    else if (held >= STB_C) nxt = P_RUN;
                end else begin
                    if (!m_h2) begin nxt = P_RST; m_relock++; end
                end
                if (soft_rst || nxt != m_ph) m_entry = m_cyc;
                m_ph = nxt;
                m_h2 = m_h1;
                m_h1 = locked;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_pll_rst",    int'(pll_rst),      int'(m_ph == P_RST));
            chk("cmp_core_rst_n", int'(core_rst_n),   int'(m_ph == P_RUN));
            chk("cmp_lock_ok",    int'(lock_ok),      int'(m_ph == P_RUN));
            chk("cmp_relock",     int'(relock_count), exp_rc(m_relock));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_run(input string name);
        int k;
        k = 0;
        while (!core_rst_n && k < 200) begin
            step();
            k++;
        end
        if (!core_rst_n) chk(name, 0, 1);
    endtask

    // Pulse soft_rst once; optionally drop locked for one cycle after edge glitch_at.
    // Returns the number of edges after the soft_rst edge at which core_rst_n rises.
    task automatic soft_measure(input int glitch_at, input int rc_before, output int rise);
        rise = 0;
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        chk("soft_pll_rst_next_edge",  int'(pll_rst),    1);
        chk("soft_core_rst_next_edge", int'(core_rst_n), 0);
        for (int k = 1; k <= 60 && rise == 0; k++) begin
            step();
            if (k == glitch_at)     locked = 1'b0;
            if (k == glitch_at + 1) locked = 1'b1;
            if (core_rst_n) rise = k;
        end
        chk("soft_relock_unchanged", int'(relock_count), exp_rc(rc_before));
    endtask

    initial begin
        int fall;
        int rise;
        int hi;
        int rises;
        int last;
        logic prev;

        rst_n = 1'b0; locked = 1'b0; soft_rst = 1'b0;
        repeat (3) step();
        chk("reset_pll_rst",    int'(pll_rst),      1);
        chk("reset_core_rst_n", int'(core_rst_n),   0);
        chk("reset_lock_ok",    int'(lock_ok),      0);
        chk("reset_relock",     int'(relock_count), 0);

        // Power-up: pll_rst pulse, then locked rises 10 cycles after release.
        rst_n = 1'b1;
        fall = 0;
        for (int k = 1; k <= 20 && fall == 0; k++) begin
            step();
            if (!pll_rst) fall = k;
        end
        chk("powerup_pll_rst_len", fall, 4);
        repeat (10 - fall) step();
        locked = 1'b1;
        rise = 0;
        for (int k = 1; k <= 40 && rise == 0; k++) begin
            step();
            if (core_rst_n) rise = k;
        end
        // First sampling edge of locked plus 2 sync + 8 stable edges.
        chk("powerup_core_release", rise, 11);
        chk("powerup_lock_ok",      int'(lock_ok),      1);
        chk("powerup_relock",       int'(relock_count), 0);

        // One-cycle lock loss in RUN.
        repeat (3) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        fall = 1;
        while (core_rst_n && fall < 10) begin
            step();
            fall++;
        end
        chk("runloss_core_fall_edges", fall, 3);
        hi = 0;
        while (pll_rst && hi < 20) begin
            hi++;
            step();
        end
        chk("runloss_pll_rst_len", hi, 4);
        chk("runloss_relock",      int'(relock_count), exp_rc(1));
        wait_run("runloss_recover");

        // soft_rst pulses: clean, glitch at stable count 5, glitch on the terminal count.
        soft_measure(-5, 1, rise);
        chk("soft_clean_release", rise, 13);
        soft_measure(8, 1, rise);
        chk("stable_glitch_restart", rise, 20);
        soft_measure(10, 1, rise);
        chk("stable_terminal_loss_wins", rise, 22);

        // soft_rst held for 20 sampling edges.
        hi = 0;
        soft_rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (pll_rst) hi++;
        end
        soft_rst = 1'b0;
        step();
        while (pll_rst && hi < 60) begin
            hi++;
            step();
        end
        // Last held edge leaves the counter at 0, which is the first of the 4 counted cycles.
        chk("soft_held_pll_rst_len", hi, 23);
        chk("soft_held_relock",      int'(relock_count), exp_rc(1));
        wait_run("soft_held_recover");

        // Asynchronous reset in the middle of WAIT_LOCK.
        locked = 1'b0;
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        repeat (6) step();
        chk("midwait_pll_rst",  int'(pll_rst),      0);
        chk("midwait_core",     int'(core_rst_n),   0);
        chk("midwait_relock",   int'(relock_count), exp_rc(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_pll_rst",    int'(pll_rst),      1);
        chk("async_core_rst_n", int'(core_rst_n),   0);
        chk("async_lock_ok",    int'(lock_ok),      0);
        chk("async_relock",     int'(relock_count), 0);
        repeat (2) step();
        rst_n = 1'b1;

        // Lock never arrives: repeated timeouts until relock_count saturates.
        rises = 0;
        last  = 0;
        prev  = pll_rst;
        for (int k = 1; k <= 260 * 54 + 20 && rises < 260; k++) begin
            step();
            if (pll_rst && !prev) begin
                rises++;
                if (rises == 1) chk("timeout_first_edge", k, 54);
                else if (rises <= 3) chk("timeout_period", k - last, 54);
                if (rises <= 3 || rises == 255 || rises == 256 || rises == 260)
                    chk("timeout_relock", int'(relock_count), exp_rc(rises));
                last = k;
            end
            prev = pll_rst;
        end
        chk("timeout_count", rises, 260);
        chk("timeout_saturated", int'(relock_count), exp_rc(255));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16, meaning the number of clk cycles pll_rst is held high per PLL reset pulse.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 100000, meaning the maximum number of cycles to wait for lock after the pulse (1 ms at 100 MHz).
REQ-003 The block SHALL have parameter LOCK_STABLE, default 1024, meaning the number of consecutive locked cycles required before core reset release.
REQ-004 The block SHALL have parameter CNT_W, default 20, meaning the phase counter width, which must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).
REQ-005 The block SHALL have port clk, input, 1 bit: free-running reference clock, the same source that feeds the PLL refclk.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-008 The block SHALL have port soft_rst, input, 1 bit: synchronous request to re-run the full PLL reset sequence.
REQ-009 The block SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL rst pin.
REQ-010 The block SHALL have port core_rst_n, output, 1 bit: active-low reset for the SpaceWire core.
REQ-011 The block SHALL have port lock_ok, output, 1 bit: high while in the RUN state.
REQ-012 The block SHALL have port relock_count, output, 8 bits: saturating count of lock timeouts plus lock losses.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer to give locked_s, adding 2 cycles of latency; all decisions SHALL use locked_s only.
REQ-014 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABLE and RUN, with one CNT_W-bit counter that clears on every state change.
REQ-015 In PLL_RST, pll_rst SHALL be 1; after PLL_RST_CYCLES cycles (counter reaches PLL_RST_CYCLES-1) the FSM SHALL go to WAIT_LOCK.
REQ-016 In WAIT_LOCK, locked_s=1 SHALL move the FSM to STABLE; if the counter reaches LOCK_TIMEOUT-1 with locked_s=0, the FSM SHALL go to PLL_RST and increment relock_count.
REQ-017 In STABLE, locked_s=0 SHALL return the FSM to WAIT_LOCK with no count increment; if the counter reaches LOCK_STABLE-1 with locked_s=1, the FSM SHALL go to RUN.
REQ-018 In RUN, locked_s=0 SHALL move the FSM to PLL_RST and increment relock_count.
REQ-019 soft_rst=1 SHALL force the FSM to PLL_RST from any state on the next edge, with no count increment; soft_rst SHALL take priority over all other transitions.
REQ-020 If soft_rst is held high, the FSM SHALL stay in PLL_RST with the counter held at 0.
REQ-021 pll_rst, core_rst_n and lock_ok SHALL be registered outputs decoded from the next state, so they change on the same edge as the state.
REQ-022 core_rst_n and lock_ok SHALL be 1 only in RUN.
REQ-023 relock_count SHALL saturate at 255 and SHALL never wrap.
REQ-024 If locked_s falls on the same cycle as the STABLE-to-RUN terminal count, the loss SHALL win and the FSM SHALL go to WAIT_LOCK.

Reset
REQ-025 rst_n=0 SHALL asynchronously set state=PLL_RST, counter=0, pll_rst=1, core_rst_n=0, lock_ok=0, relock_count=0 and both synchronizer flops to 0.
REQ-026 The first PLL_RST_CYCLES count SHALL start at the first clk edge after rst_n deasserts.
REQ-027 rst_n asserted mid-sequence SHALL abort the sequence immediately; there is no partial state retention.

Configuration
REQ-028 With macro PLL_RELOCK_COUNT_EN defined, relock_count SHALL be implemented as specified.
REQ-029 With PLL_RELOCK_COUNT_EN undefined, relock_count SHALL be constant 0, no counter flops SHALL be inferred, and the FSM behaviour SHALL be unchanged.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, macro defined)
REQ-030 The bench SHALL check: release rst_n, locked rises 10 cycles later -> pll_rst high exactly 4 cycles, core_rst_n rises 2+8 cycles after locked rises, lock_ok=1, relock_count=0.
REQ-031 The bench SHALL check: locked held 0 -> pll_rst re-pulses every 4+50 cycles and relock_count counts 1, 2, 3 ...; run more than 255 timeouts and check relock_count holds at 255.
REQ-032 The bench SHALL check: in RUN, locked drops for 1 cycle -> core_rst_n=0 within 3 cycles, a 4-cycle pll_rst pulse follows, and relock_count is incremented by 1.
REQ-033 The bench SHALL check: in STABLE, locked glitches low at stable count 5 -> the FSM returns to WAIT_LOCK, the full 8-cycle stable count restarts, and relock_count is unchanged.
REQ-034 The bench SHALL check: soft_rst pulsed in RUN -> pll_rst=1 and core_rst_n=0 on the next edge, and relock_count is unchanged; soft_rst held 20 cycles -> pll_rst stays high for 20+4 cycles.
REQ-035 The bench SHALL check: rst_n asserted mid-WAIT_LOCK, asynchronously between edges -> outputs reach reset values before the next clk edge.
